udp_rx_fcs_check: RTL and testbench

UDP_RX_FCS_CHECK -- requirements
Module: udp_rx_fcs_check

---
 rtl/udp_rx_fcs_check_if.sv | 22 ++
 rtl/udp_rx_fcs_check.sv | 146 ++++++++++++++
 tb/tb_udp_rx_fcs_check.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_fcs_check_if.sv
// GMII receive input plus the de-framed byte stream and per-frame status output.
// The master side drives GMII; the slave side is the FCS checker.
interface udp_rx_fcs_check_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        out_en;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        frame_done;
    logic [1:0]  frame_err;
    logic [15:0] frame_len;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  out_en, out_data, out_sof, frame_done, frame_err, frame_len
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output out_en, out_data, out_sof, frame_done, frame_err, frame_len
    );
endinterface

// File: rtl/udp_rx_fcs_check.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32, strips FCS through a
// 4-byte delay line, and reports length/error status once per frame.
module udp_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              rst,
    udp_rx_fcs_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [16:0] CNT_MAX     = '1;
    localparam logic [16:0] MIN_N       = 17'(MIN_LEN);
    localparam logic [16:0] MAX_N       = 17'(MAX_LEN);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      pre_cnt_q, pre_cnt_d;
    logic [31:0]     crc_q, crc_d, crc_next;
    logic [16:0]     cnt_q, cnt_d, len_full;
    logic [3:0][7:0] dly_q, dly_d;
    logic            out_en_q, out_en_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sof_q, out_sof_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [15:0]     len_q, len_d;

    assign crc_next = crc_byte(crc_q, bus.gmii_rxd);
    assign len_full = cnt_q - 17'd4;

    // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        dly_d      = dly_q;
        out_en_d   = 1'b0;
        out_data_d = 8'h00;
        out_sof_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        len_d      = len_q;

        case (state_q)
            IDLE: begin
                if (bus.gmii_rx_dv) begin
                    if (bus.gmii_rxd == 8'h55) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!bus.gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (bus.gmii_rxd == 8'hD5) begin
                    state_d = BODY;
                    crc_d   = '1;
                    cnt_d   = '0;
                end else if (bus.gmii_rxd == 8'h55 && pre_cnt_q != 3'd7) begin
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end else begin
                    state_d = DROP;
                end
            end
            BODY: begin
                if (bus.gmii_rx_dv) begin
                    crc_d = crc_next;
                    dly_d = {dly_q[2:0], bus.gmii_rxd};
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 17'd1;
                    // Once four bytes are buffered, the oldest can no longer be FCS.
                    if (cnt_q >= 17'd4) begin
                        out_en_d   = 1'b1;
                        out_data_d = dly_q[3];
                        out_sof_d  = (cnt_q == 17'd4);
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (cnt_q < 17'd4)     len_d = 16'h0000;
                    else if (len_full[16]) len_d = 16'hFFFF;
                    else                   len_d = len_full[15:0];
                    if (cnt_q > MAX_N)              err_d = 2'b11;
                    else if (cnt_q < MIN_N)         err_d = 2'b10;
                    else if (crc_q != CRC_RESIDUE)  err_d = 2'b01;
                    else                            err_d = 2'b00;
                end
            end
            DROP: begin
                if (!bus.gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the delay line is reset like any other register so no stale byte survives reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            crc_q      <= '1;
            cnt_q      <= '0;
            dly_q      <= '0;
            out_en_q   <= 1'b0;
            out_data_q <= '0;
            out_sof_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
            out_sof_q  <= out_sof_d;
            done_q     <= done_d;
            err_q      <= err_d;
            len_q      <= len_d;
        end
    end

    assign bus.out_en     = out_en_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.frame_len  = len_q;
endmodule

// File: tb/tb_udp_rx_fcs_check.sv
// Directed bench for udp_rx_fcs_check: good, CRC-error, runt, giant, bad-preamble,
// mid-frame reset and back-to-back frames.
module tb_udp_rx_fcs_check;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_rx_fcs_check_if u_if ();

    udp_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  pl[$];
    logic [7:0]  fr[$];
    logic [7:0]  rx_q[$];
    int          sof_idx[$];
    int          done_cnt = 0;
    logic [1:0]  last_err;
    logic [15:0] last_len;

    // Output monitor, sampling 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (u_if.out_en) begin
                rx_q.push_back(u_if.out_data);
                if (u_if.out_sof) sof_idx.push_back(rx_q.size() - 1);
            end else if (u_if.out_sof) begin
                sof_idx.push_back(-1);
            end
            if (u_if.frame_done) begin
                done_cnt++;
                last_err = u_if.frame_err;
                last_len = u_if.frame_len;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (pl[k]) begin
            c = c ^ {24'h0, pl[k]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build(input int n, input bit corrupt);
        logic [31:0] fcs;
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(i));
        fcs = ~ref_crc();
        fr = pl;
        for (int b = 0; b < 4; b++) fr.push_back(fcs[8*b +: 8]);
        if (corrupt) begin
            fr[10] = fr[10] ^ 8'h01;
            pl[10] = pl[10] ^ 8'h01;
        end
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        u_if.gmii_rx_dv = dv;
        u_if.gmii_rxd   = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        u_if.gmii_rx_dv = 1'b0;
        u_if.gmii_rxd   = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        sof_idx.delete();
        done_cnt = 0;
    endtask

    // Called at a falling edge; returns on the falling edge inside the frame_done cycle.
    task automatic send(input int rst_at, input logic exp_done);
        repeat (7) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < fr.size(); i++) begin
            u_if.gmii_rx_dv = 1'b1;
            u_if.gmii_rxd   = fr[i];
            if (rst_at >= 0 && i >= rst_at && i < rst_at + 3) begin
                rst = 1'b1;
                #1;
                check("rst_outputs", {3'b0, u_if.out_en, u_if.out_data, u_if.out_sof,
                      u_if.frame_done, u_if.frame_err, u_if.frame_len}, 32'h0);
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
        end
        u_if.gmii_rx_dv = 1'b0;
        u_if.gmii_rxd   = 8'h00;
        @(negedge clk);
        check("frame_done_pulse", {31'b0, u_if.frame_done}, {31'b0, exp_done});
    endtask

    task automatic check_frame(input string nm, input int exp_n, input logic [1:0] exp_err,
                               input logic [15:0] exp_len);
        int bad = 0;
        check({nm, "_out_count"}, rx_q.size(), exp_n);
        foreach (rx_q[i]) if (i >= pl.size() || rx_q[i] !== pl[i]) bad++;
        check({nm, "_data_errs"}, bad, 0);
        check({nm, "_sof_count"}, sof_idx.size(), 1);
        check({nm, "_sof_pos"}, (sof_idx.size() > 0) ? sof_idx[0] : -2, 0);
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_err"}, {30'b0, last_err}, {30'b0, exp_err});
        check({nm, "_len"}, {16'b0, last_len}, {16'b0, exp_len});
        clear_mon();
    endtask

    initial begin
        rst             = 1'b1;
        u_if.gmii_rx_dv = 1'b0;
        u_if.gmii_rxd   = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {3'b0, u_if.out_en, u_if.out_data, u_if.out_sof,
              u_if.frame_done, u_if.frame_err, u_if.frame_len}, 32'h0);
        rst = 1'b0;
        idle(2);

        // Minimum-length good frame: 60 payload + FCS = 64 bytes.
        build(60, 1'b0);
        send(-1, 1'b1);
        check_frame("good", 60, 2'b00, 16'd60);
        idle(4);

        // Bit 0 of payload byte 10 flipped after FCS generation.
        build(60, 1'b1);
        send(-1, 1'b1);
        check_frame("crc", 60, 2'b01, 16'd60);
        idle(5);
        check("hold_err", {30'b0, u_if.frame_err}, 32'd1);
        check("hold_len", {16'b0, u_if.frame_len}, 32'd60);

        // Runt: 36 payload + FCS = 40 bytes.
        build(36, 1'b0);
        send(-1, 1'b1);
        check_frame("runt", 36, 2'b10, 16'd36);
        idle(3);

        // Bad preamble, then a good frame 12 idle cycles later.
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h12);
        for (int i = 0; i < 70; i++) drive(1'b1, 8'(i));
        idle(1);
        check("badpre_no_done", {31'b0, u_if.frame_done}, 32'd0);
        idle(11);
        check("badpre_out_count", rx_q.size(), 0);
        check("badpre_done_count", done_cnt, 0);
        build(60, 1'b0);
        send(-1, 1'b1);
        check_frame("after_badpre", 60, 2'b00, 16'd60);
        idle(3);

        // Reset for 3 cycles starting at payload byte 20: bytes 0..15 were already emitted.
        build(60, 1'b0);
        send(20, 1'b0);
        idle(4);
        check("rst_out_count", rx_q.size(), 16);
        check("rst_done_count", done_cnt, 0);
        check("rst_len_cleared", {16'b0, u_if.frame_len}, 32'd0);
        clear_mon();
        build(60, 1'b0);
        send(-1, 1'b1);
        check_frame("after_rst", 60, 2'b00, 16'd60);
        idle(2);

        // Giant: 1515 payload + FCS = 1519 bytes, immediately followed by a good frame
        // whose first preamble byte lands in the frame_done cycle.
        build(1515, 1'b0);
        send(-1, 1'b1);
        check_frame("giant", 1515, 2'b11, 16'd1515);
        build(60, 1'b0);
        send(-1, 1'b1);
        check_frame("b2b", 60, 2'b00, 16'd60);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
